// File: rtl/mp_bus_pkg.sv
// Shared types and constants for the mini-processor bus master.
package mp_bus_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned WDATA_W = 32;
  localparam int unsigned RDATA_W = 64;
  localparam int unsigned OP_W    = 2;

  localparam logic [OP_W-1:0] OP_WR      = 2'b00;
  localparam logic [OP_W-1:0] OP_RD      = 2'b01;
  localparam logic [OP_W-1:0] OP_WAITINT = 2'b10;
  localparam logic [OP_W-1:0] OP_RSVD    = 2'b11;

  // Processor address map; the master itself never decodes these.
  localparam logic [ADDR_W-1:0] DATA_BASE = 16'h0100;
  localparam logic [ADDR_W-1:0] INST_BASE = 16'h0110;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = 16'h0120;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_RDWAIT,
    ST_WAITINT
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [ADDR_W-1:0]  addr;
    logic [WDATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/mp_bus_if.sv
// Processor slave-port bus: select/write/address/data plus interrupt level.
interface mp_bus_if;
  import mp_bus_pkg::*;

  logic               M_sel;
  logic               M_wr;
  logic [ADDR_W-1:0]  M_addr;
  logic [WDATA_W-1:0] M_dout;
  logic [RDATA_W-1:0] M_din;
  logic               Interrupt_in;

  modport master (
    output M_sel, M_wr, M_addr, M_dout,
    input  M_din, Interrupt_in
  );

  modport slave (
    input  M_sel, M_wr, M_addr, M_dout,
    output M_din, Interrupt_in
  );

endinterface

// File: rtl/mp_cmd_fifo.sv
// Synchronous command FIFO with first-word fall-through head; DEPTH is a power of two.
module mp_cmd_fifo
  import mp_bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic push,
  input  logic pop,
  input  cmd_t wr_data,
  output cmd_t rd_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mp_bus_master.sv
// Bus initiator for the mini-processor slave port: queued host commands, one bus
// transaction each. Optional WAITINT timeout is enabled with MP_MASTER_TIMEOUT_EN.
module mp_bus_master
  import mp_bus_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [ADDR_W-1:0]  cmd_addr,
  input  logic [WDATA_W-1:0] cmd_wdata,
  output logic               rsp_valid,
  output logic [RDATA_W-1:0] rsp_data,
  output logic               rsp_err,
  output logic               busy,
  mp_bus_if.master           bus
);

  state_e             state;
  logic               sel_q;
  logic               wr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [WDATA_W-1:0] dout_q;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  cmd_t cmd_in;
  cmd_t head;

  assign cmd_in    = '{op: cmd_op, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;
  assign pop       = (state == ST_IDLE) && !fifo_empty;
  assign busy      = !fifo_empty || (state != ST_IDLE);

  assign bus.M_sel  = sel_q;
  assign bus.M_wr   = wr_q;
  assign bus.M_addr = addr_q;
  assign bus.M_dout = dout_q;

  mp_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .push    (push),
    .pop     (pop),
    .wr_data (cmd_in),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef MP_MASTER_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

  logic [TO_W-1:0] to_cnt;
  logic            to_expired;

  assign to_expired = (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  // Timeout limit only matters when the counter is built.
  if (TIMEOUT_CYC == 0) begin : g_timeout_unused
  end
`endif

  // Sequencer: the bus/response registers are loaded on the edge entering each state.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= ST_IDLE;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      dout_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef MP_MASTER_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            case (head.op)
              OP_WR: begin
                state  <= ST_WRITE;
                sel_q  <= 1'b1;
                wr_q   <= 1'b1;
                addr_q <= head.addr;
                dout_q <= head.wdata;
              end
              OP_RD: begin
                state  <= ST_READ;
                sel_q  <= 1'b1;
                wr_q   <= 1'b0;
                addr_q <= head.addr;
              end
              OP_WAITINT: begin
                state  <= ST_WAITINT;
`ifdef MP_MASTER_TIMEOUT_EN
                to_cnt <= '0;
`endif
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
              end
            endcase
          end
        end

        ST_WRITE: begin
          sel_q <= 1'b0;
          wr_q  <= 1'b0;
          state <= ST_IDLE;
        end

        ST_READ: begin
          sel_q <= 1'b0;
          state <= ST_RDWAIT;
        end

        ST_RDWAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= bus.M_din;
          state     <= ST_IDLE;
        end

        ST_WAITINT: begin
          // An interrupt seen on the expiry cycle still counts as success.
          if (bus.Interrupt_in) begin
            rsp_valid <= 1'b1;
            state     <= ST_IDLE;
          end
`ifdef MP_MASTER_TIMEOUT_EN
          else if (to_expired) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
`endif
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mp_bus_master.sv
// Directed self-checking bench for mp_bus_master; bus and response activity is logged per cycle.
module tb_mp_bus_master;
  import mp_bus_pkg::*;

  localparam int unsigned DEPTH = 4;
`ifdef MP_MASTER_TIMEOUT_EN
  localparam int unsigned TO_CYC  = 16;
  localparam int unsigned INT_DLY = 10;
`else
  localparam int unsigned TO_CYC  = 1024;
  localparam int unsigned INT_DLY = 20;
`endif

  typedef struct {
    int          cyc;
    logic        wr;
    logic [15:0] addr;
    logic [31:0] dout;
  } bus_ev_t;

  typedef struct {
    int          cyc;
    logic [63:0] data;
    logic        err;
  } rsp_ev_t;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  mp_bus_if bus ();

  mp_bus_master #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .bus       (bus)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  bus_ev_t bus_q[$];
  rsp_ev_t rsp_q[$];

  always @(negedge Clk) begin
    if (bus.M_sel) bus_q.push_back('{cyc, bus.M_wr, bus.M_addr, bus.M_dout});
    if (rsp_valid) rsp_q.push_back('{cyc, rsp_data, rsp_err});
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                      output int pc);
    logic acc;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    acc       = 1'b0;
    for (int i = 0; i < 64 && !acc; i++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    pc = cyc;
    chk("push_accept", 64'(acc), 64'(1));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("idle_timeout", 64'(!busy), 64'(1));
    tick();
    tick();
  endtask

  int pc, icyc, b0, r0, r1;

  initial begin
    bus.M_din        = '0;
    bus.Interrupt_in = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_sel",       64'(bus.M_sel), 64'(0));
    chk("rst_wr",        64'(bus.M_wr),  64'(0));
    chk("rst_addr",      64'(bus.M_addr), 64'(0));
    chk("rst_dout",      64'(bus.M_dout), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_rsp_data",  rsp_data,       64'(0));
    chk("rst_rsp_err",   64'(rsp_err),   64'(0));
    Reset_n = 1'b1;
    tick();

    // Single write
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_WR, DATA_BASE, 32'h0000_0005, pc);
    wait_idle();
    chk("t1_nbus", 64'(bus_q.size() - b0), 64'(1));
    chk("t1_wr",   64'(bus_q[b0].wr),   64'(1));
    chk("t1_addr", 64'(bus_q[b0].addr), 64'h0100);
    chk("t1_dout", 64'(bus_q[b0].dout), 64'h5);
    chk("t1_lat",  64'(bus_q[b0].cyc - pc), 64'(1));
    chk("t1_nrsp", 64'(rsp_q.size() - r0), 64'(0));

    // Single read
    bus.M_din = 64'h0000_0000_0000_1234;
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_RD, INST_BASE, 32'h0, pc);
    wait_idle();
    chk("t2_nbus",    64'(bus_q.size() - b0), 64'(1));
    chk("t2_wr",      64'(bus_q[b0].wr),   64'(0));
    chk("t2_addr",    64'(bus_q[b0].addr), 64'h0110);
    chk("t2_nrsp",    64'(rsp_q.size() - r0), 64'(1));
    chk("t2_data",    rsp_q[r0].data, 64'h1234);
    chk("t2_err",     64'(rsp_q[r0].err), 64'(0));
    chk("t2_rsp_lat", 64'(rsp_q[r0].cyc - bus_q[b0].cyc), 64'(2));

    // Fill the queue behind a wait-int, then drain six writes in order
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_WAITINT, 16'h0, 32'h0, pc);
    for (int i = 0; i < 4; i++) push(OP_WR, 16'(DATA_BASE + 16'(i)), 32'(i), pc);
    chk("t3_full_ready", 64'(cmd_ready), 64'(0));
    chk("t3_full_busy",  64'(busy),      64'(1));
    cmd_op = OP_WR; cmd_addr = 16'h0104; cmd_wdata = 32'h4; cmd_valid = 1'b1;
    tick(); tick(); tick();
    chk("t3_still_full", 64'(cmd_ready), 64'(0));
    chk("t3_no_bus",     64'(bus_q.size() - b0), 64'(0));
    bus.Interrupt_in = 1'b1;
    tick();
    icyc = cyc;
    bus.Interrupt_in = 1'b0;
    push(OP_WR, 16'h0104, 32'h4, pc);
    push(OP_WR, 16'h0105, 32'h5, pc);
    wait_idle();
    chk("t3_nbus", 64'(bus_q.size() - b0), 64'(6));
    for (int i = 0; i < 6; i++) begin
      chk("t3_addr", 64'(bus_q[b0+i].addr), 64'(16'h0100 + 16'(i)));
      chk("t3_dout", 64'(bus_q[b0+i].dout), 64'(i));
      chk("t3_wr",   64'(bus_q[b0+i].wr),   64'(1));
      if (i > 0) chk("t3_gap", 64'(bus_q[b0+i].cyc - bus_q[b0+i-1].cyc), 64'(2));
    end
    chk("t3_nrsp",     64'(rsp_q.size() - r0), 64'(1));
    chk("t3_rsp_err",  64'(rsp_q[r0].err), 64'(0));
    chk("t3_rsp_data", rsp_q[r0].data, 64'(0));
    chk("t3_rsp_cyc",  64'(rsp_q[r0].cyc), 64'(icyc));

    // Start the processor, then wait for its interrupt
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_WR, CTRL_ADDR, 32'h1, pc);
    push(OP_WAITINT, 16'h0, 32'h0, pc);
    repeat (INT_DLY) tick();
    chk("t4_pending_rsp",  64'(rsp_q.size() - r0), 64'(0));
    chk("t4_pending_busy", 64'(busy), 64'(1));
    bus.Interrupt_in = 1'b1;
    tick();
    icyc = cyc;
    chk("t4_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("t4_rsp_err",   64'(rsp_err),   64'(0));
    bus.Interrupt_in = 1'b0;
    wait_idle();
    chk("t4_nrsp",    64'(rsp_q.size() - r0), 64'(1));
    chk("t4_rsp_cyc", 64'(rsp_q[r0].cyc), 64'(icyc));
    chk("t4_nbus",    64'(bus_q.size() - b0), 64'(1));
    chk("t4_addr",    64'(bus_q[b0].addr), 64'h0120);
    chk("t4_dout",    64'(bus_q[b0].dout), 64'h1);

    // Reserved op
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_RSVD, CTRL_ADDR, 32'hFFFF, pc);
    wait_idle();
    chk("t5_nbus",     64'(bus_q.size() - b0), 64'(0));
    chk("t5_nrsp",     64'(rsp_q.size() - r0), 64'(1));
    chk("t5_err",      64'(rsp_q[r0].err), 64'(1));
    chk("t5_data",     rsp_q[r0].data, 64'(0));
    chk("t5_lat",      64'(rsp_q[r0].cyc - pc), 64'(1));

`ifdef MP_MASTER_TIMEOUT_EN
    // Wait-int with no interrupt expires after TO_CYC cycles in WAITINT
    r0 = rsp_q.size();
    push(OP_WAITINT, 16'h0, 32'h0, pc);
    for (int i = 0; i < 60 && rsp_q.size() == r0; i++) tick();
    tick();
    chk("to_nrsp", 64'(rsp_q.size() - r0), 64'(1));
    chk("to_err",  64'(rsp_q[r0].err), 64'(1));
    chk("to_data", rsp_q[r0].data, 64'(0));
    chk("to_lat",  64'(rsp_q[r0].cyc - pc), 64'(TO_CYC + 1));
`endif

    // Reset during RDWAIT with three commands queued
    bus.M_din = 64'hFFFF_0000_FFFF_0000;
    push(OP_WAITINT, 16'h0, 32'h0, pc);
    push(OP_RD, 16'h0104, 32'h0, pc);
    push(OP_WR, 16'h0106, 32'h6, pc);
    push(OP_WR, 16'h0107, 32'h7, pc);
    push(OP_WR, 16'h0108, 32'h8, pc);
    b0 = bus_q.size();
    bus.Interrupt_in = 1'b1;
    tick();
    bus.Interrupt_in = 1'b0;
    begin
      int n;
      n = 0;
      while (n < 20 && !(bus.M_sel && !bus.M_wr)) begin
        tick();
        n++;
      end
      chk("t6_read_seen", 64'(bus.M_sel && !bus.M_wr), 64'(1));
    end
    tick();
    r1 = rsp_q.size();
    Reset_n = 1'b0;
    tick();
    chk("t6_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("t6_busy",      64'(busy),      64'(0));
    chk("t6_ready",     64'(cmd_ready), 64'(1));
    chk("t6_sel",       64'(bus.M_sel), 64'(0));
    chk("t6_addr",      64'(bus.M_addr), 64'(0));
    Reset_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_dropped_rsp", 64'(rsp_q.size() - r1), 64'(0));
    chk("t6_only_read",   64'(bus_q.size() - b0), 64'(1));
    b0 = bus_q.size(); r0 = rsp_q.size();
    push(OP_WR, 16'h0101, 32'h0000_00AB, pc);
    push(OP_RD, 16'h0102, 32'h0, pc);
    wait_idle();
    chk("t6_nbus",   64'(bus_q.size() - b0), 64'(2));
    chk("t6_w_addr", 64'(bus_q[b0].addr), 64'h0101);
    chk("t6_w_dout", 64'(bus_q[b0].dout), 64'hAB);
    chk("t6_r_addr", 64'(bus_q[b0+1].addr), 64'h0102);
    chk("t6_nrsp",   64'(rsp_q.size() - r0), 64'(1));
    chk("t6_r_data", rsp_q[r0].data, 64'hFFFF_0000_FFFF_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mp_bus_master.md
Name: mp_bus_master

Overview:
- Bus initiator that drives the mini-processor slave port (select, write, 16-bit address, 32-bit write data, 64-bit read data) and watches its interrupt line.
- Accepts host commands through a valid/ready queue and issues one bus transaction per command.
- Returns read data and interrupt-wait completion on a response strobe.
- Sits between the host/testbench side and the processor slave on the shared bus.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, ≥2)
- TIMEOUT_CYC, 1024, wait-for-interrupt limit in cycles (used only with the optional feature)

Ports:
- Clk  in  1  system clock, rising edge
- Reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept (= not full)
- cmd_op  in  2  00 write, 01 read, 10 wait-interrupt, 11 reserved
- cmd_addr  in  16  bus address
- cmd_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  64  read data; 0 for non-read responses
- rsp_err  out  1  qualifies rsp_valid: reserved op or timeout
- busy  out  1  FIFO non-empty or FSM not IDLE
- M_sel  out  1  slave select
- M_wr  out  1  1 write, 0 read
- M_addr  out  16  slave address
- M_dout  out  32  write data to slave
- M_din  in  64  read data from slave
- Interrupt_in  in  1  slave interrupt, level

Behaviour:
- Reset (synchronous, Reset_n=0 at a rising edge):
  - All outputs go to 0 except cmd_ready, which goes to 1.
  - FIFO is emptied and FSM goes to IDLE.
  - A read in flight is dropped with no response.
  - Reset overrides any push or pop in the same cycle.
- FIFO:
  - Push when cmd_valid && cmd_ready.
  - cmd_ready is low only when the FIFO holds DEPTH entries.
  - A push and a pop in the same cycle are legal whenever the FIFO is not full.
  - Pointers wrap modulo DEPTH; occupancy counter is log2(DEPTH)+1 bits.
- FSM states: IDLE, WRITE, READ, RDWAIT, WAITINT.
- IDLE:
  - If the FIFO is non-empty, pop the head and latch op/addr/data.
  - Next state: op 00 → WRITE, 01 → READ, 10 → WAITINT.
  - Op 11 → stay in IDLE and pulse rsp_valid=1, rsp_err=1 on the following cycle, with no bus activity.
- WRITE: for exactly one cycle, M_sel=1, M_wr=1, M_addr/M_dout = latched values; then IDLE. No response.
- READ: for exactly one cycle, M_sel=1, M_wr=0, M_addr driven; then RDWAIT.
- RDWAIT:
  - M_sel=0.
  - M_din is sampled at the end of this cycle.
  - Next cycle: rsp_valid=1, rsp_data=M_din, rsp_err=0; FSM back in IDLE.
- WAITINT:
  - Bus idle.
  - When Interrupt_in=1 is sampled: rsp_valid=1, rsp_data=0, rsp_err=0 next cycle; back to IDLE.
  - If Interrupt_in is already high on entry, completion comes one cycle after entry.
- Bus outputs are registered.
  - M_sel/M_wr are 0 whenever no transaction is active.
  - M_addr/M_dout hold their last value when idle.
- Throughput: a command needs one IDLE cycle plus one bus cycle; back-to-back writes therefore give M_sel high every other cycle.
- Processor address map used by software/tests:
  - 0x0100–0x010F data registers
  - 0x0110–0x011F instruction registers
  - 0x0120 control (write 1 = start, 0 = idle)
- The block does not decode or check addresses.

Optional Feature:
- MP_MASTER_TIMEOUT_EN defined:
  - WAITINT runs a cycle counter, cleared on entry.
  - If TIMEOUT_CYC cycles elapse without an interrupt: rsp_valid=1, rsp_err=1, rsp_data=0; back to IDLE.
  - An interrupt arriving in the same cycle as expiry counts as success.
- MP_MASTER_TIMEOUT_EN undefined: WAITINT waits indefinitely, and no counter logic is synthesized.

Decomposition:
- Package mp_bus_pkg:
  - op-code constants (OP_WR, OP_RD, OP_WAITINT, OP_RSVD)
  - FSM state encoding
  - address constants (DATA_BASE 16'h0100, INST_BASE 16'h0110, CTRL_ADDR 16'h0120)
  - bus widths (ADDR_W 16, WDATA_W 32, RDATA_W 64)
- Sub-module mp_cmd_fifo: parameterised synchronous FIFO holding {op, addr, wdata} = 50 bits, with full/empty outputs.

Test Plan:
- After reset, push write(0x0100, 0x0000_0005) → one cycle with M_sel=1, M_wr=1, M_addr=0x0100, M_dout=5; no rsp_valid.
- Read(0x0110) with the slave returning 64'h0000_0000_0000_1234 → M_sel=1, M_wr=0 for one cycle; two cycles later rsp_valid=1, rsp_data=0x1234, rsp_err=0.
- Hold cmd_valid with 6 writes while DEPTH=4 → cmd_ready drops after the queue fills; all 6 writes appear on the bus in order (addresses 0x0100..0x0105); pointers wrap correctly.
- Write(0x0120, 1), then wait-int; raise Interrupt_in 20 cycles later → exactly one rsp_valid with rsp_err=0, one cycle after the interrupt is sampled.
- Op 11 → rsp_valid=1, rsp_err=1, M_sel stays 0. With MP_MASTER_TIMEOUT_EN and TIMEOUT_CYC=16, wait-int with no interrupt → rsp_err=1 after 16 cycles.
- Assert Reset_n=0 during RDWAIT with 3 entries queued → no response, busy=0, cmd_ready=1, M_sel=0 on the next cycle; the following command executes normally.
